bi_gry_and_gry_bi: RTL and testbench

Bidirectional code converter between binary and reflected Gray code. A mode input selects the direction: Gray→binary or binary→Gray. Results are registered, one cycle of latency. Used in counter/pointer paths, e.g. FIFO pointer CDC encoding and decoding, where a registered, width-parameterised converter is needed.

---
 rtl/bi_gry_and_gry_bi.sv | 72 +++++++
 tb/tb_bi_gry_and_gry_bi.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bi_gry_and_gry_bi.sv
// Registered bidirectional binary <-> reflected Gray converter, one cycle latency.
// en selects direction per accepted word; the idle-direction output register holds.
module bi_gry_and_gry_bi #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Binarycode,
  output logic [WIDTH-1:0] Graycode,
  output logic             out_valid,
  output logic             out_mode
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] gray_to_bin;
  logic [WIDTH-1:0] bin_to_gray;

  // Bit i of the decoded value is the XOR of din[WIDTH-1:i]; the shifted
  // reduction avoids a self-referencing chain inside the block.
  always_comb begin
    gray_to_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gray_to_bin[i] = ^(din >> i);
    end
    bin_to_gray = din ^ (din >> 1);
  end

  // Conversion results are only steered into the registers when accepted, so
  // an undriven din while idle never reaches the outputs.
  always_comb begin
    bin_d   = bin_q;
    gray_d  = gray_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    if (in_valid) begin
      valid_d = 1'b1;
      mode_d  = en;
      if (en) begin
        bin_d = gray_to_bin;
      end else begin
        gray_d = bin_to_gray;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  assign Binarycode = bin_q;
  assign Graycode   = gray_q;
  assign out_valid  = valid_q;
  assign out_mode   = mode_q;

endmodule

// File: tb/tb_bi_gry_and_gry_bi.sv
// Directed bench for bi_gry_and_gry_bi: behavioural model feeds a scoreboard
// queue at drive time; entries are popped and compared after the clock edge.
module tb_bi_gry_and_gry_bi;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         v;
    logic         m;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         en;
  logic         in_valid;
  logic [W-1:0] Binarycode;
  logic [W-1:0] Graycode;
  logic         out_valid;
  logic         out_mode;

  int total = 0;
  int bad   = 0;

  exp_t         sb[$];
  logic [W-1:0] mb, mg;
  logic         mv, mm;
  logic [W-1:0] obs_gray [16];

  bi_gry_and_gry_bi #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .en         (en),
    .in_valid   (in_valid),
    .Binarycode (Binarycode),
    .Graycode   (Graycode),
    .out_valid  (out_valid),
    .out_mode   (out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ {1'b0, b[W-1:1]};
  endfunction

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    r[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, push the model's prediction, then
  // pop and compare on the next falling edge.
  task automatic step(input logic [W-1:0] d, input logic m, input logic v, input logic r);
    exp_t e;
    din      = d;
    en       = m;
    in_valid = v;
    rst      = r;
    if (r) begin
      mb = '0; mg = '0; mv = 1'b0; mm = 1'b0;
    end else begin
      mv = v;
      if (v) begin
        mm = m;
        if (m) mb = g2b(d);
        else   mg = b2g(d);
      end
    end
    sb.push_back('{b: mb, g: mg, v: mv, m: mm});
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("Binarycode", 64'(Binarycode), 64'(e.b));
      chk("Graycode",   64'(Graycode),   64'(e.g));
      chk("out_valid",  64'(out_valid),  64'(e.v));
      chk("out_mode",   64'(out_mode),   64'(e.m));
    end
  endtask

  initial begin
    logic [W-1:0] r4;
    rst = 1'b1; din = '0; en = 1'b0; in_valid = 1'b0;
    mb = '0; mg = '0; mv = 1'b0; mm = 1'b0;
    @(negedge clk);

    // Reset with a valid request pending must discard it.
    step(4'b1111, 1'b1, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1, 1'b1);
    chk("reset_bin",   64'(Binarycode), 64'h0);
    chk("reset_valid", 64'(out_valid),  64'h0);

    step(4'b1101, 1'b1, 1'b1, 1'b0);
    chk("g2b_1101",      64'(Binarycode), 64'b1001);
    chk("g2b_gray_hold", 64'(Graycode),   64'b0000);
    chk("g2b_mode",      64'(out_mode),   64'h1);

    step(4'b0010, 1'b0, 1'b1, 1'b0);
    chk("b2g_0010",     64'(Graycode),   64'b0011);
    chk("b2g_bin_hold", 64'(Binarycode), 64'b1001);

    step(4'b1111, 1'b0, 1'b1, 1'b0); chk("b2g_1111", 64'(Graycode),   64'b1000);
    step(4'b1000, 1'b1, 1'b1, 1'b0); chk("g2b_1000", 64'(Binarycode), 64'b1111);
    step(4'b0000, 1'b0, 1'b1, 1'b0); chk("b2g_0000", 64'(Graycode),   64'b0000);
    step(4'b0000, 1'b1, 1'b1, 1'b0); chk("g2b_0000", 64'(Binarycode), 64'b0000);
    step(4'b1000, 1'b0, 1'b1, 1'b0); chk("b2g_1000", 64'(Graycode),   64'b1100);

    for (int v = 0; v < 16; v++) begin
      step(W'(v), 1'b0, 1'b1, 1'b0);
      obs_gray[v] = Graycode;
      step(obs_gray[v], 1'b1, 1'b1, 1'b0);
      chk("round_trip", 64'(Binarycode), 64'(v));
    end
    for (int v = 0; v < 16; v++) begin
      chk("gray_one_bit_step", 64'($countones(obs_gray[v] ^ obs_gray[(v + 1) % 16])), 64'd1);
    end

    for (int i = 0; i < 8; i++) begin
      r4 = W'($urandom_range(0, 15));
      step(r4, i[0], 1'b1, 1'b0);
    end

    // Idle cycles with an undriven bus: outputs must hold.
    step('x, 1'b1, 1'b0, 1'b0);
    step('x, 1'b0, 1'b0, 1'b0);

    step(4'b0101, 1'b1, 1'b1, 1'b0);
    step(4'b0110, 1'b0, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("post_reset_bin",  64'(Binarycode), 64'h0);
    chk("post_reset_gray", 64'(Graycode),   64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
